// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer and the decoder next to it:
// opcode values, fetch FSM states and instruction field positions.
package instr_fetch_sequencer_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 64;

  localparam logic [7:0] OPC_FETCH_WEIGHT = 8'h01;
  localparam logic [7:0] OPC_FETCH_DATA   = 8'h02;
  localparam logic [7:0] OPC_FETCH_BIAS   = 8'h04;
  localparam logic [7:0] OPC_COMPUTE      = 8'h40;
  localparam logic [7:0] OPC_CONFIG       = 8'h81;
  localparam logic [7:0] OPC_END          = 8'h82;
  localparam logic [7:0] OPC_HOLD         = 8'h44;

  localparam int OPC_MSB = 63;
  localparam int OPC_LSB = 56;
  localparam int REG_W   = 8;

  // reg_1 is the byte directly under the opcode, reg_7 the least significant byte
  function automatic int reg_lsb(input int n);
    return OPC_LSB - REG_W * n;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_ISSUE,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Walks a program in synchronous-read instruction memory and issues one instruction
// per REQ/CAPT/ISSUE round, honouring back-pressure, HOLD/resume and END/count limits.
module instr_fetch_sequencer #(
  parameter int         ADDR_W   = instr_fetch_sequencer_pkg::ADDR_W_DEF,
  parameter int         INSTR_W  = instr_fetch_sequencer_pkg::INSTR_W_DEF,
  parameter logic [7:0] OPC_END  = instr_fetch_sequencer_pkg::OPC_END,
  parameter logic [7:0] OPC_HOLD = instr_fetch_sequencer_pkg::OPC_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  instr_count,
  input  logic               resume,
  input  logic               exe_busy,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_rd_addr,
  input  logic [INSTR_W-1:0] imem_rd_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_enable,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_busy,
  output logic               hold_active,
  output logic               fetch_done
);
  import instr_fetch_sequencer_pkg::*;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  pc_d, count_q, count_d, issued_q, issued_d, issued_inc;
  logic [INSTR_W-1:0] buf_q, buf_d, instruction_d;
  logic [ADDR_W-1:0]  imem_rd_addr_d;
  logic [7:0]         opcode;
  logic               issue, count_hit, count_hit_inc;
  logic               imem_rd_en_d, instr_enable_d, fetch_busy_d, hold_active_d, fetch_done_d;

  assign opcode        = buf_q[OPC_MSB:OPC_LSB];
  assign issue         = (state == ST_ISSUE) && !exe_busy;
  assign issued_inc    = issued_q + ADDR_W'(1);
  assign count_hit     = (count_q != '0) && (issued_q == count_q);
  assign count_hit_inc = (count_q != '0) && (issued_inc == count_q);

  // State and datapath register; every output is registered here as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      buf_q        <= '0;
      imem_rd_en   <= 1'b0;
      imem_rd_addr <= '0;
      instruction  <= '0;
      instr_enable <= 1'b0;
      fetch_busy   <= 1'b0;
      hold_active  <= 1'b0;
      fetch_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state        <= state_d;
      pc           <= pc_d;
      count_q      <= count_d;
      issued_q     <= issued_d;
      buf_q        <= buf_d;
      imem_rd_en   <= imem_rd_en_d;
      imem_rd_addr <= imem_rd_addr_d;
      instruction  <= instruction_d;
      instr_enable <= instr_enable_d;
      fetch_busy   <= fetch_busy_d;
      hold_active  <= hold_active_d;
      fetch_done   <= fetch_done_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state;
    unique case (state)
      ST_IDLE:  if (start) state_d = ST_REQ;
      ST_REQ:   state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!exe_busy) begin
          if (opcode == OPC_END)       state_d = ST_DONE;
          else if (opcode == OPC_HOLD) state_d = ST_HOLD;
          else if (count_hit_inc)      state_d = ST_DONE;
          else                         state_d = ST_REQ;
        end
      end
      ST_HOLD:  if (resume) state_d = count_hit ? ST_DONE : ST_REQ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with the state they describe.
  always_comb begin
    pc_d     = pc;
    count_d  = count_q;
    issued_d = issued_q;
    buf_d    = buf_q;
    if (state == ST_IDLE && start) begin
      pc_d     = base_addr;
      count_d  = instr_count;
      issued_d = '0;
    end
    if (state == ST_CAPT) buf_d = imem_rd_data;
    if (issue) begin
      pc_d     = pc + ADDR_W'(1);
      issued_d = issued_inc;
    end
    imem_rd_en_d   = (state_d == ST_REQ);
    imem_rd_addr_d = imem_rd_en_d ? pc_d : '0;
    instr_enable_d = issue;
    instruction_d  = issue ? buf_q : '0;
    fetch_busy_d   = (state_d != ST_IDLE);
    hold_active_d  = (state_d == ST_HOLD);
    fetch_done_d   = (state == ST_DONE);
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a behavioural sync-read instruction memory.
module tb_instr_fetch_sequencer;
  localparam int AW = 10;
  localparam int IW = 64;

  logic          clk = 1'b0;
  logic          rst, start, resume, exe_busy;
  logic [AW-1:0] base_addr, instr_count;
  logic          imem_rd_en;
  logic [AW-1:0] imem_rd_addr;
  logic [IW-1:0] imem_rd_data;
  logic [IW-1:0] instruction;
  logic          instr_enable;
  logic [AW-1:0] pc;
  logic          fetch_busy, hold_active, fetch_done;

  logic [IW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int zero_viol = 0;
  logic [IW-1:0] iss_q[$];
  int            iss_cyc[$];
  logic [AW-1:0] rd_q[$];
  int            done_cyc[$];

  instr_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .instr_count(instr_count),
    .resume(resume), .exe_busy(exe_busy), .imem_rd_en(imem_rd_en), .imem_rd_addr(imem_rd_addr),
    .imem_rd_data(imem_rd_data), .instruction(instruction), .instr_enable(instr_enable),
    .pc(pc), .fetch_busy(fetch_busy), .hold_active(hold_active), .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd_en) imem_rd_data <= mem[imem_rd_addr];
  end

  always @(negedge clk) begin
    if (instr_enable) begin
      iss_q.push_back(instruction);
      iss_cyc.push_back(cyc);
    end
    if (imem_rd_en) rd_q.push_back(imem_rd_addr);
    if (fetch_done) done_cyc.push_back(cyc);
    if (!instr_enable && instruction !== '0) zero_viol++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_q.delete(); iss_cyc.delete(); rd_q.delete(); done_cyc.delete();
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input logic [AW-1:0] count);
    start = 1'b1; base_addr = base; instr_count = count;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (done_cyc.size() == 0 && n < limit) begin
      step();
      n++;
    end
    n_cmp++;
    if (done_cyc.size() == 0) begin
      n_bad++;
      $display("FAIL %s_timeout: no fetch_done within %0d cycles", name, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_addr = 10'h123; instr_count = 10'd5;
    resume = 1'b0; exe_busy = 1'b0;
    step(); step();
    n_cmp++;
    if ({imem_rd_en, imem_rd_addr, instruction, instr_enable, pc, fetch_busy, hold_active, fetch_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rd_en=%b addr=%h instr=%h en=%b pc=%h busy=%b hold=%b done=%b, want all 0",
               imem_rd_en, imem_rd_addr, instruction, instr_enable, pc, fetch_busy, hold_active, fetch_done);
    end
    rst = 1'b0; start = 1'b0;
    step();
    n_cmp++;
    if (fetch_busy !== 1'b0) begin
      n_bad++; $display("FAIL start_with_rst: fetch_busy=%b want 0", fetch_busy);
    end
  endtask

  task automatic test_linear();
    logic [IW-1:0] exp_w [3];
    exp_w[0] = 64'h0100_0000_0000_0010;
    exp_w[1] = 64'h0200_0000_0000_0011;
    exp_w[2] = 64'h4000_0000_0000_0012;
    for (int i = 0; i < 3; i++) mem[10'h010 + i] = exp_w[i];
    clear_logs();
    pulse_start(10'h010, 10'd3);
    wait_done(60, "linear");
    n_cmp++;
    if (iss_q.size() != 3) begin
      n_bad++; $display("FAIL linear_count: %0d issues want 3", iss_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (iss_q[i] !== exp_w[i]) begin
          n_bad++; $display("FAIL linear_word%0d: %h want %h", i, iss_q[i], exp_w[i]);
        end
        n_cmp++;
        if (rd_q.size() > i && rd_q[i] !== 10'h010 + AW'(i)) begin
          n_bad++; $display("FAIL linear_rd%0d: %h want %h", i, rd_q[i], 10'h010 + AW'(i));
        end
      end
      n_cmp++;
      if (iss_cyc[1] - iss_cyc[0] != 3 || iss_cyc[2] - iss_cyc[1] != 3) begin
        n_bad++; $display("FAIL linear_spacing: %0d,%0d want 3,3", iss_cyc[1] - iss_cyc[0], iss_cyc[2] - iss_cyc[1]);
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] - iss_cyc[2] != 1) begin
        n_bad++; $display("FAIL linear_done_timing: %0d pulses, delay %0d want 1 pulse delay 1",
                          done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - iss_cyc[2] : -1);
      end
    end
    n_cmp++;
    if (pc !== 10'h013) begin
      n_bad++; $display("FAIL linear_pc: %h want 013", pc);
    end
  endtask

  task automatic test_end();
    for (int i = 0; i < 5; i++) mem[i] = 64'h0100_0000_0000_0000 + IW'(i);
    mem[5] = 64'h8200_0000_0000_0000;
    mem[6] = 64'h0400_0000_0000_0006;
    clear_logs();
    pulse_start(10'h000, 10'd0);
    wait_done(80, "end");
    repeat (5) step();
    n_cmp++;
    if (iss_q.size() != 6) begin
      n_bad++; $display("FAIL end_count: %0d issues want 6", iss_q.size());
    end else begin
      n_cmp++;
      if (iss_q[4] !== 64'h0100_0000_0000_0004 || iss_q[5] !== 64'h8200_0000_0000_0000) begin
        n_bad++; $display("FAIL end_words: %h %h want 0100000000000004 8200000000000000", iss_q[4], iss_q[5]);
      end
    end
    n_cmp++;
    if (rd_q.size() != 6 || rd_q[rd_q.size()-1] !== 10'h005) begin
      n_bad++; $display("FAIL end_reads: %0d reads want 6 ending at 005", rd_q.size());
    end
    n_cmp++;
    if (pc !== 10'h006) begin
      n_bad++; $display("FAIL end_pc: %h want 006", pc);
    end
  endtask

  task automatic test_back_pressure();
    mem[10'h020] = 64'h0400_0000_0000_00A0;
    mem[10'h021] = 64'h8100_0000_0000_00A1;
    clear_logs();
    exe_busy = 1'b1;
    pulse_start(10'h020, 10'd2);
    repeat (7) step();
    n_cmp++;
    if (iss_q.size() != 0 || fetch_busy !== 1'b1 || imem_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL bp_stall: issues=%0d busy=%b rd_en=%b want 0 1 0", iss_q.size(), fetch_busy, imem_rd_en);
    end
    exe_busy = 1'b0;
    step();
    n_cmp++;
    if (instr_enable !== 1'b1 || instruction !== 64'h0400_0000_0000_00A0) begin
      n_bad++; $display("FAIL bp_release: en=%b instr=%h want 1 04000000000000a0", instr_enable, instruction);
    end
    step();
    n_cmp++;
    if (instr_enable !== 1'b0) begin
      n_bad++; $display("FAIL bp_duplicate: en=%b want 0", instr_enable);
    end
    wait_done(40, "bp");
    n_cmp++;
    if (iss_q.size() != 2 || iss_q[iss_q.size()-1] !== 64'h8100_0000_0000_00A1 || pc !== 10'h022) begin
      n_bad++; $display("FAIL bp_total: issues=%0d pc=%h want 2 issues ending 81000000000000a1, pc 022", iss_q.size(), pc);
    end
  endtask

  task automatic test_hold();
    int n = 0;
    mem[0] = 64'h0100_0000_0000_0000;
    mem[1] = 64'h0200_0000_0000_0001;
    mem[2] = 64'h4400_0000_0000_0002;
    mem[3] = 64'h4000_0000_0000_0003;
    mem[4] = 64'h8200_0000_0000_0004;
    clear_logs();
    pulse_start(10'h000, 10'd0);
    step();
    resume = 1'b1;
    step();
    resume = 1'b0;
    while (hold_active !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (hold_active !== 1'b1 || iss_q.size() != 3 || iss_q[iss_q.size()-1] !== 64'h4400_0000_0000_0002) begin
      n_bad++; $display("FAIL hold_enter: hold=%b issues=%0d want 1 and 3 issues ending 4400000000000002", hold_active, iss_q.size());
    end
    repeat (4) step();
    n_cmp++;
    if (hold_active !== 1'b1 || rd_q.size() != 3 || imem_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL hold_stay: hold=%b reads=%0d rd_en=%b want 1 3 0", hold_active, rd_q.size(), imem_rd_en);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    n_cmp++;
    if (imem_rd_en !== 1'b1 || imem_rd_addr !== 10'h003 || hold_active !== 1'b0) begin
      n_bad++; $display("FAIL hold_resume: rd_en=%b addr=%h hold=%b want 1 003 0", imem_rd_en, imem_rd_addr, hold_active);
    end
    wait_done(40, "hold");
    n_cmp++;
    if (iss_q.size() != 5 || pc !== 10'h005) begin
      n_bad++; $display("FAIL hold_total: issues=%0d pc=%h want 5 005", iss_q.size(), pc);
    end
  endtask

  task automatic test_hold_count();
    int n = 0;
    mem[10'h060] = 64'h0100_0000_0000_0060;
    mem[10'h061] = 64'h4400_0000_0000_0061;
    mem[10'h062] = 64'h0200_0000_0000_0062;
    clear_logs();
    pulse_start(10'h060, 10'd2);
    while (hold_active !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    n_cmp++;
    if (imem_rd_en !== 1'b0 || hold_active !== 1'b0) begin
      n_bad++; $display("FAIL holdcnt_resume: rd_en=%b hold=%b want 0 0", imem_rd_en, hold_active);
    end
    wait_done(10, "holdcnt");
    n_cmp++;
    if (iss_q.size() != 2 || rd_q.size() != 2) begin
      n_bad++; $display("FAIL holdcnt_total: issues=%0d reads=%0d want 2 2", iss_q.size(), rd_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    mem[10'h3FE] = 64'h0100_0000_0000_03FE;
    mem[10'h3FF] = 64'h0200_0000_0000_03FF;
    mem[10'h000] = 64'h4000_0000_0000_0400;
    mem[10'h001] = 64'h8100_0000_0000_0401;
    mem[10'h100] = 64'h0400_0000_0000_0100;
    clear_logs();
    pulse_start(10'h3FE, 10'd4);
    repeat (4) step();
    pulse_start(10'h100, 10'd1);
    wait_done(80, "wrap");
    repeat (6) step();
    n_cmp++;
    if (rd_q.size() != 4) begin
      n_bad++; $display("FAIL wrap_reads: %0d reads want 4", rd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rd_q[i] !== exp_a[i]) begin
          n_bad++; $display("FAIL wrap_addr%0d: %h want %h", i, rd_q[i], exp_a[i]);
        end
      end
    end
    n_cmp++;
    if (iss_q.size() != 4 || iss_q[iss_q.size()-1] !== 64'h8100_0000_0000_0401) begin
      n_bad++; $display("FAIL wrap_issues: %0d issues want 4 ending 8100000000000401", iss_q.size());
    end
    n_cmp++;
    if (pc !== 10'h002 || done_cyc.size() != 1 || fetch_busy !== 1'b0) begin
      n_bad++; $display("FAIL wrap_end: pc=%h done=%0d busy=%b want 002 1 0", pc, done_cyc.size(), fetch_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    mem[10'h040] = 64'h0100_0000_0000_0040;
    mem[10'h050] = 64'h0200_0000_0000_0050;
    clear_logs();
    exe_busy = 1'b1;
    pulse_start(10'h040, 10'd0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({imem_rd_en, imem_rd_addr, instruction, instr_enable, pc, fetch_busy, hold_active, fetch_done} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs: en=%b pc=%h busy=%b instr=%h want all 0", instr_enable, pc, fetch_busy, instruction);
    end
    exe_busy = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (iss_q.size() != 0 || rd_q.size() != 1 || fetch_busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_quiet: issues=%0d reads=%0d busy=%b want 0 1 0", iss_q.size(), rd_q.size(), fetch_busy);
    end
    pulse_start(10'h050, 10'd1);
    wait_done(40, "midrst");
    n_cmp++;
    if (iss_q.size() != 1 || iss_q[0] !== 64'h0200_0000_0000_0050 || pc !== 10'h051) begin
      n_bad++; $display("FAIL midrst_restart: issues=%0d pc=%h want 1 issue 0200000000000050, pc 051", iss_q.size(), pc);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_linear();
    test_end();
    test_back_pressure();
    test_hold();
    test_hold_count();
    test_wrap();
    test_reset_mid_run();
    n_cmp++;
    if (zero_viol != 0) begin
      n_bad++; $display("FAIL instr_zero_when_idle: %0d cycles with nonzero instruction, want 0", zero_viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
